sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port Avalon-MM style arbiter in front of a single SDRAM
// controller. One command is in flight toward the controller at a time; read
// tags are queued so returning data is steered to the issuing port in order.
//
// Optional feature macro: SDRAM_ARB_RR_EN
//   defined   -> round-robin grant between simultaneous requesters
//   undefined -> fixed priority, port 0 wins
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   s0_* / s1_*                     slave ports: address, read, write,
//                                   writedata, byteenable, waitrequest,
//                                   readdata, readdatavalid
//   m_*                             master port toward sdram_controller_0
//   err                             sticky flag: readdatavalid with no
//                                   outstanding read
module sdram_arbiter #(
  parameter int unsigned AW        = 24,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // port 0
  input  logic [AW-1:0]     s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DW-1:0]     s0_writedata,
  input  logic [DW/8-1:0]   s0_byteenable,
  output logic              s0_waitrequest,
  output logic [DW-1:0]     s0_readdata,
  output logic              s0_readdatavalid,
  // port 1
  input  logic [AW-1:0]     s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DW-1:0]     s1_writedata,
  input  logic [DW/8-1:0]   s1_byteenable,
  output logic              s1_waitrequest,
  output logic [DW-1:0]     s1_readdata,
  output logic              s1_readdatavalid,
  // master
  output logic [AW-1:0]     m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DW-1:0]     m_writedata,
  output logic [DW/8-1:0]   m_byteenable,
  input  logic              m_waitrequest,
  input  logic [DW-1:0]     m_readdata,
  input  logic              m_readdatavalid,
  output logic              err
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          m_address_q, m_address_d;
  logic [DW-1:0]          m_writedata_q, m_writedata_d;
  logic [BW-1:0]          m_byteenable_q, m_byteenable_d;
  logic                   m_read_q, m_read_d;
  logic                   m_write_q, m_write_d;
  logic                   cmd_port_q, cmd_port_d;
  logic [MAX_OUTST-1:0]   tag_mem_q, tag_mem_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DW-1:0]          rd_data_q, rd_data_d;
  logic                   rdv0_q, rdv0_d;
  logic                   rdv1_q, rdv1_d;
  logic                   err_q, err_d;
`ifdef SDRAM_ARB_RR_EN
  logic                   last_q, last_d;
`endif

  logic fifo_full, fifo_empty;
  logic elig0, elig1;
  logic grant0, grant1;
  logic can_grant;
  logic push, pop;
  logic sel_write;

  assign fifo_full  = (count_q == CW'(MAX_OUTST));
  assign fifo_empty = (count_q == '0);

  // A read blocked by a full tag FIFO makes the port ineligible; writes never are.
  assign elig0 = s0_write | (s0_read & ~fifo_full);
  assign elig1 = s1_write | (s1_read & ~fifo_full);

  // Grants are only offered in IDLE and never while reset is asserted.
  assign can_grant = (state_q == IDLE) & reset_n;

  // Arbitration between eligible ports.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_grant) begin
`ifdef SDRAM_ARB_RR_EN
      if (elig0 && elig1) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
`else
      grant0 = elig0;
      grant1 = elig1 & ~elig0;
`endif
    end
  end

  assign push = m_read_q & ~m_waitrequest;
  assign pop  = m_readdatavalid & ~fifo_empty;

  // Sim-and-write together is treated as a write.
  assign sel_write = grant1 ? s1_write : s0_write;

  // Next-state: command FSM, tag FIFO, read-return register, error flag.
  always_comb begin
    state_d        = state_q;
    m_address_d    = m_address_q;
    m_writedata_d  = m_writedata_q;
    m_byteenable_d = m_byteenable_q;
    m_read_d       = m_read_q;
    m_write_d      = m_write_q;
    cmd_port_d     = cmd_port_q;
    tag_mem_d      = tag_mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    rd_data_d      = rd_data_q;
    rdv0_d         = 1'b0;
    rdv1_d         = 1'b0;
    err_d          = err_q;
`ifdef SDRAM_ARB_RR_EN
    last_d         = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d        = ISSUE;
          cmd_port_d     = grant1;
          m_address_d    = grant1 ? s1_address    : s0_address;
          m_writedata_d  = grant1 ? s1_writedata  : s0_writedata;
          m_byteenable_d = grant1 ? s1_byteenable : s0_byteenable;
          m_write_d      = sel_write;
          m_read_d       = ~sel_write;
`ifdef SDRAM_ARB_RR_EN
          last_d         = grant1;
`endif
        end
      end
      ISSUE: begin
        if (!m_waitrequest) begin
          state_d   = IDLE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      tag_mem_d[wr_ptr_q] = cmd_port_q;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      rd_data_d = m_readdata;
      rdv0_d    = ~tag_mem_q[rd_ptr_q];
      rdv1_d    = tag_mem_q[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Data with nothing outstanding is dropped and flagged.
    if (m_readdatavalid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      m_address_q    <= '0;
      m_writedata_q  <= '0;
      m_byteenable_q <= '0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      cmd_port_q     <= 1'b0;
      tag_mem_q      <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      rdv0_q         <= 1'b0;
      rdv1_q         <= 1'b0;
      err_q          <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_q         <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      m_address_q    <= m_address_d;
      m_writedata_q  <= m_writedata_d;
      m_byteenable_q <= m_byteenable_d;
      m_read_q       <= m_read_d;
      m_write_q      <= m_write_d;
      cmd_port_q     <= cmd_port_d;
      tag_mem_q      <= tag_mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      rdv0_q         <= rdv0_d;
      rdv1_q         <= rdv1_d;
      err_q          <= err_d;
`ifdef SDRAM_ARB_RR_EN
      last_q         <= last_d;
`endif
    end
  end

  // Waitrequest is combinational so the grant is visible in the request cycle.
  assign s0_waitrequest   = ~grant0;
  assign s1_waitrequest   = ~grant1;
  assign s0_readdata      = rd_data_q;
  assign s1_readdata      = rd_data_q;
  assign s0_readdatavalid = rdv0_q;
  assign s1_readdatavalid = rdv1_q;
  assign m_address        = m_address_q;
  assign m_read           = m_read_q;
  assign m_write          = m_write_q;
  assign m_writedata      = m_writedata_q;
  assign m_byteenable     = m_byteenable_q;
  assign err              = err_q;

endmodule
